// File: rtl/wb_pkg.sv
// Shared writeback-stage constants: stall-vector indices and valid/zero encodings.
package wb_pkg;

    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    localparam logic        avail     = 1'b1;
    localparam logic        unavail   = 1'b0;
    localparam logic [31:0] zero_word = 32'h0000_0000;

endpackage

// File: rtl/wb_collide.sv
// Intra-bundle write-collision filter: a lower lane loses its write enable when
// a higher lane (later in program order) writes the same register.
module wb_collide #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LANES  = 1
) (
    input  logic [LANES-1:0]        in_wen,
    input  logic [LANES*ADDR_W-1:0] in_addr,
    output logic [LANES-1:0]        out_wen
);

    always_comb begin
        out_wen = in_wen;
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (in_wen[i] && in_wen[j] &&
                    (in_addr[i*ADDR_W +: ADDR_W] == in_addr[j*ADDR_W +: ADDR_W])) begin
                    out_wen[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline stage: 2-entry skid FIFO of multi-lane write bundles with
// stall-vector bubble/hold, flush, collision masking and a retired-bundle counter.
module wb_pipe_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned LANES   = 1,
    parameter int unsigned STALL_W = 6,
    parameter int unsigned STAGE   = STALL_MEM
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [LANES-1:0]          in_wen,
    input  logic [LANES*ADDR_W-1:0]   in_addr,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [LANES-1:0]          out_wen,
    output logic [LANES*ADDR_W-1:0]   out_addr,
    output logic [LANES*DATA_W-1:0]   out_data,
    input  logic                      out_ready,
    output logic [31:0]               ret_cnt
);

    logic                    head_valid_q, head_valid_d;
    logic [LANES-1:0]        head_wen_q,   head_wen_d;
    logic [LANES*ADDR_W-1:0] head_addr_q,  head_addr_d;
    logic [LANES*DATA_W-1:0] head_data_q,  head_data_d;

    logic                    skid_valid_q, skid_valid_d;
    logic [LANES-1:0]        skid_wen_q,   skid_wen_d;
    logic [LANES*ADDR_W-1:0] skid_addr_q,  skid_addr_d;
    logic [LANES*DATA_W-1:0] skid_data_q,  skid_data_d;

    logic [31:0]             ret_cnt_q,    ret_cnt_d;

    logic [LANES-1:0]        clean_wen;
    logic                    stage_stall;
    logic                    hold;
    logic                    enq;
    logic                    deq;

    wb_collide #(
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_collide (
        .in_wen  (in_wen),
        .in_addr (in_addr),
        .out_wen (clean_wen)
    );

    // Stalling this stage blocks intake; the next stage also stalled freezes output.
    assign stage_stall = stall[STAGE];
    assign hold        = stall[STAGE] & stall[STAGE+1];

    assign in_ready = ~skid_valid_q & ~stage_stall;
    assign deq      = head_valid_q & out_ready & ~hold;
    assign enq      = in_valid & in_ready & ~flush;

    always_comb begin
        head_valid_d = head_valid_q;
        head_wen_d   = head_wen_q;
        head_addr_d  = head_addr_q;
        head_data_d  = head_data_q;
        skid_valid_d = skid_valid_q;
        skid_wen_d   = skid_wen_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        ret_cnt_d    = ret_cnt_q;

        if (deq) begin
            ret_cnt_d = ret_cnt_q + 32'd1;
        end

        if (flush) begin
            head_valid_d = unavail;
            head_wen_d   = '0;
            head_addr_d  = '0;
            head_data_d  = '0;
            skid_valid_d = unavail;
            skid_wen_d   = '0;
            skid_addr_d  = '0;
            skid_data_d  = '0;
        end else begin
            if (deq) begin
                head_valid_d = skid_valid_q;
                head_wen_d   = skid_wen_q;
                head_addr_d  = skid_addr_q;
                head_data_d  = skid_data_q;
                skid_valid_d = unavail;
                skid_wen_d   = '0;
                skid_addr_d  = '0;
                skid_data_d  = '0;
            end
            // New bundle lands in the lowest entry left free after the dequeue.
            if (enq) begin
                if (head_valid_d == unavail) begin
                    head_valid_d = avail;
                    head_wen_d   = clean_wen;
                    head_addr_d  = in_addr;
                    head_data_d  = in_data;
                end else begin
                    skid_valid_d = avail;
                    skid_wen_d   = clean_wen;
                    skid_addr_d  = in_addr;
                    skid_data_d  = in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_q <= unavail;
            head_wen_q   <= '0;
            head_addr_q  <= '0;
            head_data_q  <= '0;
            skid_valid_q <= unavail;
            skid_wen_q   <= '0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            ret_cnt_q    <= zero_word;
        end else begin
            head_valid_q <= head_valid_d;
            head_wen_q   <= head_wen_d;
            head_addr_q  <= head_addr_d;
            head_data_q  <= head_data_d;
            skid_valid_q <= skid_valid_d;
            skid_wen_q   <= skid_wen_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            ret_cnt_q    <= ret_cnt_d;
        end
    end

    assign out_valid = head_valid_q;
    assign out_wen   = head_valid_q ? head_wen_q  : '0;
    assign out_addr  = head_valid_q ? head_addr_q : '0;
    assign out_data  = head_valid_q ? head_data_q : '0;
    assign ret_cnt   = ret_cnt_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage (LANES=2): vector table plus corner-case sequences,
// checked against a bundle scoreboard and an occupancy/counter model.
module tb_wb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_wen;
    logic [9:0]  in_addr;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [1:0]  out_wen;
    logic [9:0]  out_addr;
    logic [63:0] out_data;
    logic        out_ready;
    logic [31:0] ret_cnt;

    typedef struct packed {
        logic [1:0]  wen;
        logic [9:0]  addr;
        logic [63:0] data;
    } bundle_t;

    typedef struct {
        logic [1:0]  wen;
        logic [9:0]  addr;
        logic [63:0] data;
        logic [1:0]  exp_wen;
    } vec_t;

    bundle_t     sb[$];
    vec_t        vecs[7];
    logic [1:0]  cur_ew;
    logic [31:0] exp_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    wb_pipe_stage #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .LANES   (2),
        .STALL_W (6),
        .STAGE   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_wen    (in_wen),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_wen   (out_wen),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ret_cnt   (ret_cnt)
    );

    function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic drive(input logic v, input logic [1:0] w, input logic [9:0] a,
                         input logic [63:0] d, input logic [1:0] ew);
        in_valid = v;
        in_wen   = w;
        in_addr  = a;
        in_data  = d;
        cur_ew   = ew;
    endtask

    // One clock: sample mid-cycle, update the model for the coming edge, return at edge+1.
    task automatic cycle();
        bundle_t exp;
        logic    hold;
        logic    accept;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            hold   = stall[4] & stall[5];
            accept = in_valid && (sb.size() < 2) && !stall[4] && !flush;
            chk("in_ready", {79'b0, in_ready}, {79'b0, (sb.size() < 2) && !stall[4]});
            chk("out_valid", {79'b0, out_valid}, {79'b0, sb.size() != 0});
            chk("ret_cnt", {48'b0, ret_cnt}, {48'b0, exp_cnt});
            if (sb.size() != 0) begin
                exp = sb[0];
                chk("head_wen", {78'b0, out_wen}, {78'b0, exp.wen});
                chk("head_addr", {70'b0, out_addr}, {70'b0, exp.addr});
                chk("head_data", {16'b0, out_data}, {16'b0, exp.data});
                if (out_ready && !hold) begin
                    exp = sb.pop_front();
                    exp_cnt = exp_cnt + 32'd1;
                end
            end else begin
                chk("idle_out", {4'b0, out_wen, out_addr, out_data}, 80'b0);
            end
            if (flush) sb.delete();
            else if (accept) sb.push_back('{cur_ew, in_addr, in_data});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{2'b11, {5'd7, 5'd3},   {32'hAA, 32'h55},             2'b11};
        vecs[1] = '{2'b11, {5'd5, 5'd5},   {32'h2, 32'h1},               2'b10};
        vecs[2] = '{2'b01, {5'd5, 5'd5},   {32'h1234, 32'h5678},         2'b01};
        vecs[3] = '{2'b10, {5'd9, 5'd9},   {32'hDEAD_BEEF, 32'h0},       2'b10};
        vecs[4] = '{2'b00, {5'd4, 5'd4},   {32'h1, 32'h2},               2'b00};
        vecs[5] = '{2'b01, {5'd3, 5'd0},   {32'h77, 32'h66},             2'b01};
        vecs[6] = '{2'b11, {5'd31, 5'd30}, {32'hFFFF_FFFF, 32'h8000_0001}, 2'b11};

        rst = 1'b1; stall = '0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, '0, '0, 2'b00);
        exp_cnt = '0;
        cycle(); cycle();
        rst = 1'b0;
        chk("rst_out_valid", {79'b0, out_valid}, 80'b0);
        chk("rst_ret_cnt", {48'b0, ret_cnt}, 80'b0);

        // Single transfer
        out_ready = 1'b1;
        drive(1'b1, 2'b11, {5'd7, 5'd3}, {32'hAA, 32'h55}, 2'b11);
        cycle();
        drive(1'b0, 2'b00, '0, '0, 2'b00);
        chk("t1_valid", {79'b0, out_valid}, {79'b0, 1'b1});
        chk("t1_wen", {78'b0, out_wen}, {78'b0, 2'b11});
        cycle();
        chk("t1_cnt", {48'b0, ret_cnt}, 80'd1);

        // Vector table, back-to-back with out_ready high
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].wen, vecs[i].addr, vecs[i].data, vecs[i].exp_wen);
            cycle();
        end
        drive(1'b0, 2'b00, '0, '0, 2'b00);
        cycle(); cycle();
        chk("tbl_cnt", {48'b0, ret_cnt}, 80'd8);

        // Back-pressure: A, B accepted, C held upstream until space frees
        out_ready = 1'b0;
        drive(1'b1, 2'b01, {5'd1, 5'd1}, {32'h0, 32'hA}, 2'b01); cycle();
        drive(1'b1, 2'b01, {5'd2, 5'd2}, {32'h0, 32'hB}, 2'b01); cycle();
        drive(1'b1, 2'b01, {5'd3, 5'd3}, {32'h0, 32'hC}, 2'b01);
        chk("bp_ready_low", {79'b0, in_ready}, 80'b0);
        cycle(); cycle();
        out_ready = 1'b1;
        cycle(); cycle();
        drive(1'b0, 2'b00, '0, '0, 2'b00);
        cycle(); cycle();
        chk("bp_cnt", {48'b0, ret_cnt}, 80'd11);

        // Bubble: head delivered, nothing accepted, then empty
        out_ready = 1'b0;
        drive(1'b1, 2'b10, {5'd8, 5'd0}, {32'h11, 32'h0}, 2'b10); cycle();
        out_ready = 1'b1; stall = 6'b010000;
        drive(1'b1, 2'b10, {5'd9, 5'd0}, {32'h22, 32'h0}, 2'b10);
        cycle(); cycle();
        chk("bubble_empty", {79'b0, out_valid}, 80'b0);
        stall = '0;
        drive(1'b0, 2'b00, '0, '0, 2'b00);
        cycle();

        // Hold: head frozen, counter frozen
        out_ready = 1'b0;
        drive(1'b1, 2'b10, {5'd10, 5'd0}, {32'h33, 32'h0}, 2'b10); cycle();
        out_ready = 1'b1; stall = 6'b110000;
        cycle(); cycle(); cycle();
        chk("hold_cnt", {48'b0, ret_cnt}, 80'd12);
        chk("hold_data", {16'b0, out_data}, {16'b0, 32'h33, 32'h0});
        stall = '0;
        drive(1'b0, 2'b00, '0, '0, 2'b00);
        cycle(); cycle();

        // Flush of a full FIFO with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h44}, 2'b01); cycle();
        drive(1'b1, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h55}, 2'b01); cycle();
        flush = 1'b1; cycle();
        flush = 1'b0;
        drive(1'b0, 2'b00, '0, '0, 2'b00);
        chk("flush_valid", {79'b0, out_valid}, 80'b0);
        chk("flush_ready", {79'b0, in_ready}, {79'b0, 1'b1});
        chk("flush_cnt", {48'b0, ret_cnt}, 80'd13);
        cycle();

        // Flush coinciding with a dequeue still retires that bundle
        drive(1'b1, 2'b01, {5'd0, 5'd6}, {32'h0, 32'h66}, 2'b01); cycle();
        drive(1'b0, 2'b00, '0, '0, 2'b00);
        out_ready = 1'b1; flush = 1'b1; cycle();
        flush = 1'b0;
        cycle();
        chk("flush_deq_cnt", {48'b0, ret_cnt}, 80'd14);

        // Counter wrap
        out_ready = 1'b0;
        drive(1'b1, 2'b01, {5'd0, 5'd7}, {32'h0, 32'h77}, 2'b01); cycle();
        drive(1'b0, 2'b00, '0, '0, 2'b00);
        force dut.ret_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.ret_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        cycle(); cycle();
        chk("wrap_cnt", {48'b0, ret_cnt}, 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
